dmem_responder: RTL

- Data-memory responder (target side) for the core's load/store port.
- Accepts one request at a time over a valid/ready request channel and waits a programmable latency.
- Performs byte/half/word access with RISC-V funct3 semantics.
- Returns data and status on a valid/ready response channel.
- Replaces the combinational data memory when the core moves to a handshaked memory interface.

---
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one load/store at a time, fixed LATENCY wait, RISC-V funct3 access.
// Optional macro DMEM_ERR_EN enables fault detection; without it accesses are forced aligned and wrapped.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int         AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        wr_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, commit;
  logic          legal, is_half, is_word, acc_err;
  logic [1:0]    lane;
  logic [29:0]   idx;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wlane, rd_word, ld_data;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] ln,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{ln, 3'b000} +: 8];
    h = ln[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Access decode on the latched request; illegal funct3 falls back to a word access.
  always_comb begin
    legal   = wr_q ? (f3_q inside {3'b000, 3'b001, 3'b010})
                   : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    is_word = !legal || (f3_q[1:0] == 2'b10);
    is_half = legal && (f3_q[1:0] == 2'b01);
    lane    = addr_q[1:0];
    idx     = addr_q[31:2];
    acc_err = 1'b0;
`ifdef DMEM_ERR_EN
    acc_err = !legal || (idx >= 30'(DEPTH_WORDS)) || (is_half && lane[0]) ||
              (is_word && (lane != 2'b00));
`else
    if (is_half) lane[0] = 1'b0;
    if (is_word) lane = 2'b00;
    idx = 30'({2'b00, idx} % 32'(DEPTH_WORDS));
`endif
    widx = idx[AW-1:0];
    if (is_word) begin
      be    = 4'b1111;
      wlane = wdata_q;
    end else if (is_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wlane = {2{wdata_q[15:0]}};
    end else begin
      be    = 4'b0001 << lane;
      wlane = {4{wdata_q[7:0]}};
    end
  end

  assign rd_word = mem[widx];
  assign ld_data = load_extend(rd_word, lane, f3_q);
  assign accept  = (state_q == S_IDLE) && req_valid && req_ready_q;
  assign commit  = (state_q == S_WAIT) && (cnt_q == LAT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          cnt_d       = 4'd0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (commit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (wr_q || acc_err) ? 32'd0 : ld_data;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      f3_q    <= req_funct3;
      wdata_q <= req_wdata;
    end
  end

  // Stores land only on the final wait edge, so a reset while waiting drops them.
  always_ff @(posedge clk) begin
    if (commit && wr_q && !acc_err && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule
